alu_share_arbiter: RTL and testbench

- Round-robin controller that shares one 32-bit combinational bitwise ALU datapath (AND/OR/XOR/NOT) between two requesters.
- Registers each accepted operand set onto the ALU inputs and waits a fixed settle interval, sized for gate-delay propagation.
- Captures the ALU output and returns it to the owning requester over a valid/ready response channel.
- Only one operation is in flight at a time.

---
 rtl/alu_share_arbiter_if.sv | 44 ++++
 rtl/alu_share_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Handshake and ALU bus bundle for alu_share_arbiter.
// slave: the arbiter side. master: requesters, responders and the shared ALU.
interface alu_share_arbiter_if #(
   parameter int unsigned WIDTH = 32
);
   logic             req0_valid;
   logic             req0_ready;
   logic [1:0]       req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req1_valid;
   logic             req1_ready;
   logic [1:0]       req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             rsp0_valid;
   logic             rsp0_ready;
   logic [WIDTH-1:0] rsp0_data;
   logic             rsp1_valid;
   logic             rsp1_ready;
   logic [WIDTH-1:0] rsp1_data;
   logic [1:0]       alu_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_s;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp0_ready, rsp1_ready, alu_s,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
      output alu_op, alu_a, alu_b
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp0_ready, rsp1_ready, alu_s,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
      input  alu_op, alu_a, alu_b
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational bitwise ALU between two requesters.
// One operation in flight: IDLE (grant) -> SETTLE (hold ALU inputs) -> RESP.
// Optional macro ALU_SHARE_ARBITER_STATS_EN adds saturating per-requester
// grant counters grant_cnt0/grant_cnt1.
module alu_share_arbiter #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned WIDTH         = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_share_arbiter_if.slave   bus,
`ifdef ALU_SHARE_ARBITER_STATS_EN
   output logic [15:0]          grant_cnt0,
   output logic [15:0]          grant_cnt1,
`endif
   output logic                 busy
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned STAT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             prio_q, prio_d;      // id preferred when both request
   logic             gnt_q, gnt_d;        // id of the operation in flight
   logic [1:0]       alu_op_q, alu_op_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [WIDTH-1:0] rsp0_data_q, rsp0_data_d;
   logic [WIDTH-1:0] rsp1_data_q, rsp1_data_d;
   logic             rsp0_valid_q, rsp0_valid_d;
   logic             rsp1_valid_q, rsp1_valid_d;
   logic             busy_q, busy_d;

   logic             gnt_id_c;
   logic             acc0_c, acc1_c;

   // Combinational grant: only in IDLE and never while reset is asserted.
   always_comb begin
      gnt_id_c       = 1'b0;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         gnt_id_c = prio_q;
      end else if (bus.req1_valid) begin
         gnt_id_c = 1'b1;
      end
      if (rst_n && (state_q == ST_IDLE)) begin
         bus.req0_ready = bus.req0_valid && !gnt_id_c;
         bus.req1_ready = bus.req1_valid &&  gnt_id_c;
      end
   end

   assign acc0_c = bus.req0_valid && bus.req0_ready;
   assign acc1_c = bus.req1_valid && bus.req1_ready;

   // Next-state and datapath register updates.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      prio_d       = prio_q;
      gnt_d        = gnt_q;
      alu_op_d     = alu_op_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      rsp0_data_d  = rsp0_data_q;
      rsp1_data_d  = rsp1_data_q;
      rsp0_valid_d = rsp0_valid_q;
      rsp1_valid_d = rsp1_valid_q;
      unique case (state_q)
         ST_IDLE: begin
            if (acc0_c || acc1_c) begin
               if (gnt_id_c) begin
                  alu_op_d = bus.req1_op;
                  alu_a_d  = bus.req1_a;
                  alu_b_d  = bus.req1_b;
               end else begin
                  alu_op_d = bus.req0_op;
                  alu_a_d  = bus.req0_a;
                  alu_b_d  = bus.req0_b;
               end
               gnt_d   = gnt_id_c;
               cnt_d   = CNT_W'(SETTLE_CYCLES);
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RESP;
               if (gnt_q) begin
                  rsp1_data_d  = bus.alu_s;
                  rsp1_valid_d = 1'b1;
               end else begin
                  rsp0_data_d  = bus.alu_s;
                  rsp0_valid_d = 1'b1;
               end
            end
         end
         ST_RESP: begin
            if (gnt_q ? bus.rsp1_ready : bus.rsp0_ready) begin
               state_d      = ST_IDLE;
               prio_d       = ~gnt_q;
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         prio_q       <= 1'b0;
         gnt_q        <= 1'b0;
         alu_op_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         rsp0_data_q  <= '0;
         rsp1_data_q  <= '0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         prio_q       <= prio_d;
         gnt_q        <= gnt_d;
         alu_op_q     <= alu_op_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         rsp0_data_q  <= rsp0_data_d;
         rsp1_data_q  <= rsp1_data_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.alu_op     = alu_op_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.rsp0_data  = rsp0_data_q;
   assign bus.rsp1_data  = rsp1_data_q;
   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign busy           = busy_q;

`ifdef ALU_SHARE_ARBITER_STATS_EN
   logic [STAT_W-1:0] grant_cnt0_q, grant_cnt0_d;
   logic [STAT_W-1:0] grant_cnt1_q, grant_cnt1_d;

   // Saturating accept counters.
   always_comb begin
      grant_cnt0_d = grant_cnt0_q;
      grant_cnt1_d = grant_cnt1_q;
      if (acc0_c && (grant_cnt0_q != {STAT_W{1'b1}})) begin
         grant_cnt0_d = grant_cnt0_q + STAT_W'(1);
      end
      if (acc1_c && (grant_cnt1_q != {STAT_W{1'b1}})) begin
         grant_cnt1_d = grant_cnt1_q + STAT_W'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant_cnt0_q <= '0;
         grant_cnt1_q <= '0;
      end else begin
         grant_cnt0_q <= grant_cnt0_d;
         grant_cnt1_q <= grant_cnt1_d;
      end
   end

   assign grant_cnt0 = grant_cnt0_q;
   assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (SETTLE_CYCLES = 2).
module tb_alu_share_arbiter;

   localparam int unsigned WIDTH = 32;

   logic clk;
   logic rst_n;
   logic busy;
`ifdef ALU_SHARE_ARBITER_STATS_EN
   logic [15:0] grant_cnt0;
   logic [15:0] grant_cnt1;
`endif

   int chk_cnt = 0;
   int err_cnt = 0;

   alu_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

   alu_share_arbiter #(
      .SETTLE_CYCLES(2),
      .WIDTH(WIDTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
`ifdef ALU_SHARE_ARBITER_STATS_EN
      .grant_cnt0(grant_cnt0),
      .grant_cnt1(grant_cnt1),
`endif
      .busy(busy)
   );

   // Shared bitwise ALU driven by the registered operands.
   always_comb begin
      case (bus.alu_op)
         2'b00:   bus.alu_s = bus.alu_a & bus.alu_b;
         2'b01:   bus.alu_s = bus.alu_a | bus.alu_b;
         2'b10:   bus.alu_s = bus.alu_a ^ bus.alu_b;
         default: bus.alu_s = ~bus.alu_a;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req0_op    = 2'b10;
      bus.req0_a     = 32'hFFFF0000;
      bus.req0_b     = 32'h0F0F0F0F;
      bus.req1_valid = 1'b1;
      bus.req1_op    = 2'b00;
      bus.req1_a     = 32'h12345678;
      bus.req1_b     = 32'h0000FFFF;
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;

      // Reset held two cycles with both requesters valid.
      cyc();
      cyc();
      check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
      check("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
      check("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
      check("rst_alu_a", bus.alu_a, 32'd0);
      check("rst_alu_b", bus.alu_b, 32'd0);
      check("rst_alu_op", 32'(bus.alu_op), 32'd0);
      check("rst_rsp0_data", bus.rsp0_data, 32'd0);
      check("rst_rsp1_data", bus.rsp1_data, 32'd0);
      rst_n = 1'b1;
      #1;
      check("post_rst_req0_ready", 32'(bus.req0_ready), 32'd1);
      check("post_rst_req1_ready", 32'(bus.req1_ready), 32'd0);

      // XOR from requester 0 wins contention.
      cyc();
      bus.req0_valid = 1'b0;
      check("xor_alu_a", bus.alu_a, 32'hFFFF0000);
      check("xor_alu_b", bus.alu_b, 32'h0F0F0F0F);
      check("xor_alu_op", 32'(bus.alu_op), 32'd2);
      check("xor_busy", 32'(busy), 32'd1);
      check("xor_settle_req1_ready", 32'(bus.req1_ready), 32'd0);
      cyc();
      check("xor_early_valid", 32'(bus.rsp0_valid), 32'd0);
      cyc();
      check("xor_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
      check("xor_rsp0_data", bus.rsp0_data, 32'hF0F00F0F);
      check("xor_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
      check("xor_resp_req1_ready", 32'(bus.req1_ready), 32'd0);
      cyc();
      check("xor_done_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
      check("xor_done_busy", 32'(busy), 32'd0);
      check("rr_req1_ready", 32'(bus.req1_ready), 32'd1);

      // AND from requester 1.
      cyc();
      bus.req1_valid = 1'b0;
      check("and_alu_a", bus.alu_a, 32'h12345678);
      cyc();
      cyc();
      check("and_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
      check("and_rsp1_data", bus.rsp1_data, 32'h00005678);
      check("and_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);

      // Both valid again: pointer now prefers requester 0. OR under backpressure.
      bus.req0_valid = 1'b1;
      bus.req0_op    = 2'b01;
      bus.req0_a     = 32'hA5A50000;
      bus.req0_b     = 32'h00005A5A;
      bus.req1_valid = 1'b1;
      bus.rsp0_ready = 1'b0;
      cyc();
      check("rr2_req0_ready", 32'(bus.req0_ready), 32'd1);
      check("rr2_req1_ready", 32'(bus.req1_ready), 32'd0);
      cyc();
      bus.req0_valid = 1'b0;
      cyc();
      cyc();
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
         check("bp_rsp0_data", bus.rsp0_data, 32'hA5A55A5A);
         check("bp_busy", 32'(busy), 32'd1);
         check("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
         cyc();
      end
      bus.rsp0_ready = 1'b1;
      #1;
      check("bp_last_req1_ready", 32'(bus.req1_ready), 32'd0);
      cyc();
      check("bp_done_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
      check("bp_done_busy", 32'(busy), 32'd0);
      check("bp_done_req1_ready", 32'(bus.req1_ready), 32'd1);
      cyc();
      bus.req1_valid = 1'b0;
      check("acc1_busy", 32'(busy), 32'd1);
      check("acc1_alu_a", bus.alu_a, 32'h12345678);
`ifdef ALU_SHARE_ARBITER_STATS_EN
      check("stats_cnt0", 32'(grant_cnt0), 32'd2);
      check("stats_cnt1", 32'(grant_cnt1), 32'd2);
`endif

      // Reset in the middle of SETTLE aborts the operation.
      cyc();
      check("mid_settle_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
      check("abort_alu_a", bus.alu_a, 32'd0);
`ifdef ALU_SHARE_ARBITER_STATS_EN
      check("stats_rst_cnt0", 32'(grant_cnt0), 32'd0);
      check("stats_rst_cnt1", 32'(grant_cnt1), 32'd0);
`endif
      bus.req0_valid = 1'b1;
      bus.req0_op    = 2'b11;
      bus.req0_a     = 32'h0000FFFF;
      bus.req0_b     = 32'h12345678;
      bus.req1_valid = 1'b1;
      #1;
      check("abort_req0_ready", 32'(bus.req0_ready), 32'd1);
      check("abort_req1_ready", 32'(bus.req1_ready), 32'd0);
      cyc();
      bus.req0_valid = 1'b0;
      check("not_rsp1_valid_a", 32'(bus.rsp1_valid), 32'd0);
`ifdef ALU_SHARE_ARBITER_STATS_EN
      check("stats_not_cnt0", 32'(grant_cnt0), 32'd1);
      check("stats_not_cnt1", 32'(grant_cnt1), 32'd0);
`endif
      cyc();
      check("not_rsp1_valid_b", 32'(bus.rsp1_valid), 32'd0);
      cyc();
      check("not_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
      check("not_rsp0_data", bus.rsp0_data, 32'hFFFF0000);
      check("not_rsp1_valid_c", 32'(bus.rsp1_valid), 32'd0);
      cyc();
      check("not_done_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
      bus.req1_valid = 1'b0;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule
